// File: rtl/inst_fetcher_pkg.sv
// inst_fetcher_pkg: shared definitions for the instruction fetch front end.
//   - fetch_state_e : fetcher FSM state encoding
//   - is_rvc()      : RVC length test on a 16-bit parcel (16-bit unless [1:0]==2'b11)
package inst_fetcher_pkg;

    typedef enum logic [1:0] {
        S_LOOK    = 2'd0,
        S_WAIT_LO = 2'd1,
        S_WAIT_HI = 2'd2,
        S_VALID   = 2'd3
    } fetch_state_e;

    function automatic logic is_rvc(input logic [15:0] half);
        return half[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_align.sv
// fetch_align: combinational instruction extraction from a 32-bit word.
// Ports:
//   word_in         : word containing the instruction's first parcel
//   pc_hi_in        : pc[1]; selects upper (1) or lower (0) halfword of word_in
//   next_half_in    : low halfword of the following word (upper parcel of a split inst)
//   is_compressed   : selected parcel is a 16-bit instruction
//   needs_next_word : 32-bit instruction starting at the upper halfword
//   inst_out        : assembled instruction, 16-bit forms zero-extended
module fetch_align
    import inst_fetcher_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic        pc_hi_in,
    input  logic [15:0] next_half_in,
    output logic        is_compressed,
    output logic        needs_next_word,
    output logic [31:0] inst_out
);

    logic [15:0] half;

    always_comb begin
        half            = pc_hi_in ? word_in[31:16] : word_in[15:0];
        is_compressed   = is_rvc(half);
        needs_next_word = pc_hi_in && !is_compressed;
        if (is_compressed) begin
            inst_out = {16'h0000, half};
        end else if (pc_hi_in) begin
            inst_out = {next_half_in, half};
        end else begin
            inst_out = word_in;
        end
    end

endmodule

// File: rtl/inst_fetcher.sv
// inst_fetcher: fetches aligned words from the icache, extracts one 16/32-bit
// instruction at a halfword-aligned PC and holds it until the decoder issues it.
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global freeze when low)
//   icache_req_valid/icache_req_addr   : one-cycle word request
//   icache_resp_valid/icache_resp_data : response pulse with the word
//   start_decode/inst/inst_addr        : instruction presented to the decoder
//   issue_signal/next_pc               : decoder accepted inst, successor PC
//   wrong_predicted/correct_pc         : flush and redirect
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        icache_req_valid,
    output logic [31:0] icache_req_addr,
    input  logic        icache_resp_valid,
    input  logic [31:0] icache_resp_data,
    output logic        start_decode,
    output logic [31:0] inst,
    output logic [31:0] inst_addr,
    input  logic        issue_signal,
    input  logic [31:0] next_pc,
    input  logic        wrong_predicted,
    input  logic [31:0] correct_pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         buf_valid_q, buf_valid_d;
    logic [29:0]  buf_addr_q, buf_addr_d;
    logic [31:0]  buf_data_q, buf_data_d;
    logic         drop_q, drop_d;
    logic [15:0]  lo_half_q, lo_half_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_addr_q, inst_addr_d;
    logic         req_valid_q, req_valid_d;
    logic [31:0]  req_addr_q, req_addr_d;

    logic [31:0]  align_word;
    logic         align_pc_hi;
    logic         align_compressed;
    logic         align_needs_next;
    logic [31:0]  align_inst;
    logic         buf_hit;
    logic [29:0]  pc_word_nxt;

    assign buf_hit     = buf_valid_q && (buf_addr_q == pc_q[31:2]);
    assign pc_word_nxt = pc_q[31:2] + 30'd1;   // wraps to word 0 after 0xFFFF_FFFC

    // The aligner sees the buffer in S_LOOK, the fresh word in S_WAIT_LO, and in
    // S_WAIT_HI the held low parcel placed in the upper half so pc_hi=1 selects it.
    always_comb begin
        case (state_q)
            S_WAIT_LO: begin
                align_word  = icache_resp_data;
                align_pc_hi = pc_q[1];
            end
            S_WAIT_HI: begin
                align_word  = {lo_half_q, 16'h0000};
                align_pc_hi = 1'b1;
            end
            default: begin
                align_word  = buf_data_q;
                align_pc_hi = pc_q[1];
            end
        endcase
    end

    fetch_align u_align (
        .word_in         (align_word),
        .pc_hi_in        (align_pc_hi),
        .next_half_in    (icache_resp_data[15:0]),
        .is_compressed   (align_compressed),
        .needs_next_word (align_needs_next),
        .inst_out        (align_inst)
    );

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= S_LOOK;
            pc_q        <= RESET_PC;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            drop_q      <= 1'b0;
            lo_half_q   <= '0;
            inst_q      <= '0;
            inst_addr_q <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            drop_q      <= drop_d;
            lo_half_q   <= lo_half_d;
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        // A pending discard is consumed by whichever response arrives next.
        drop_d      = drop_q && !icache_resp_valid;
        lo_half_d   = lo_half_q;
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;
        req_valid_d = 1'b0;
        req_addr_d  = req_addr_q;

        if (wrong_predicted) begin
            pc_d    = correct_pc;
            state_d = S_LOOK;
            // A response arriving in this very cycle closes the request, so
            // there is nothing left in flight to discard.
            if ((state_q == S_WAIT_LO || state_q == S_WAIT_HI) && !icache_resp_valid) begin
                drop_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_LOOK: begin
                    if (buf_hit && !align_needs_next) begin
                        inst_d      = align_inst;
                        inst_addr_d = pc_q;
                        state_d     = S_VALID;
                    end else if (!drop_q) begin
                        // No new request while a stale one is still in flight.
                        req_valid_d = 1'b1;
                        if (buf_hit) begin
                            lo_half_d  = buf_data_q[31:16];
                            req_addr_d = {pc_word_nxt, 2'b00};
                            state_d    = S_WAIT_HI;
                        end else begin
                            req_addr_d = {pc_q[31:2], 2'b00};
                            state_d    = S_WAIT_LO;
                        end
                    end
                end
                S_WAIT_LO: begin
                    if (icache_resp_valid) begin
                        buf_valid_d = 1'b1;
                        buf_addr_d  = req_addr_q[31:2];
                        buf_data_d  = icache_resp_data;
                        if (!align_needs_next) begin
                            inst_d      = align_inst;
                            inst_addr_d = pc_q;
                            state_d     = S_VALID;
                        end else begin
                            lo_half_d   = icache_resp_data[31:16];
                            req_valid_d = 1'b1;
                            req_addr_d  = {pc_word_nxt, 2'b00};
                            state_d     = S_WAIT_HI;
                        end
                    end
                end
                S_WAIT_HI: begin
                    if (icache_resp_valid) begin
                        buf_valid_d = 1'b1;
                        buf_addr_d  = req_addr_q[31:2];
                        buf_data_d  = icache_resp_data;
                        inst_d      = align_inst;
                        inst_addr_d = pc_q;
                        state_d     = S_VALID;
                    end
                end
                S_VALID: begin
                    if (issue_signal) begin
                        pc_d    = next_pc;
                        state_d = S_LOOK;
                    end
                end
                default: state_d = S_LOOK;
            endcase
        end
    end

    // Outputs
    always_comb begin
        start_decode     = (state_q == S_VALID);
        inst             = inst_q;
        inst_addr        = inst_addr_q;
        icache_req_valid = req_valid_q;
        icache_req_addr  = req_addr_q;
    end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
Front-end producer for the RVC-capable decoder.
- Fetches 32-bit aligned words from the instruction cache.
- Extracts one 16-bit or 32-bit instruction at a halfword-aligned PC.
- Presents it as inst/inst_addr/start_decode and holds it until the decoder issues it.
- Takes the decoder's next_pc on issue. Redirects to correct_pc on wrong_predicted.
- Keeps a one-word buffer so consecutive compressed instructions in one word need no second request.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded at reset.

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset; asynchronous, active-low
rdy_in  input  1  global ready; state frozen when low
icache_req_valid  output  1  one-cycle request pulse
icache_req_addr  output  32  word address, [1:0]=0
icache_resp_valid  input  1  response pulse, at least 1 cycle after request
icache_resp_data  input  32  little-endian word
start_decode  output  1  inst/inst_addr valid
inst  output  32  instruction; 16-bit forms zero-extended to {16'b0,half}
inst_addr  output  32  PC of inst
issue_signal  input  1  decoder accepted inst this cycle
next_pc  input  32  decoder's successor PC; sampled on issue_signal
wrong_predicted  input  1  flush from ROB
correct_pc  input  32  redirect target

Behaviour:
- Reset (async, rst_in=0):
  - pc=RESET_PC, state=S_LOOK, buf_valid=0, drop=0.
  - start_decode=0, icache_req_valid=0, inst=0, inst_addr=0.
- rdy_in=0: no register changes. icache is gated by the same rdy_in, so no response arrives.
- Length rule: a halfword with [1:0]!=2'b11 is 16-bit, otherwise 32-bit.
- Buffer: buf_addr (word), buf_data. A hit means buf_valid and buf_addr==pc[31:2].
- States:
  - S_LOOK:
    - buffer hit, and the instruction is complete (pc[1]=0; or pc[1]=1 and 16-bit): latch inst → S_VALID.
    - buffer hit but pc[1]=1 and 32-bit: hold the low half, pulse request for pc+2 word → S_WAIT_HI.
    - miss: pulse request for {pc[31:2],2'b00} → S_WAIT_LO. Suppressed while drop=1 (stay in S_LOOK).
  - S_WAIT_LO, on resp:
    - load buffer.
    - if complete, latch inst → S_VALID.
    - else request next word → S_WAIT_HI.
  - S_WAIT_HI, on resp:
    - load buffer with the new word.
    - inst = {resp[15:0], low half} → S_VALID.
  - S_VALID:
    - start_decode=1; inst/inst_addr stable.
    - on issue_signal: pc<=next_pc, start_decode=0 next cycle → S_LOOK.
    - jalr_stall is absorbed by the decoder (issue_signal stays low); the fetcher simply holds.
- Latency:
  - buffer hit: start_decode 2 cycles after issue (1 S_LOOK cycle).
  - miss: start_decode the cycle after resp.
  - split 32-bit: cycle after the second resp.
- wrong_predicted (highest priority, any state):
  - pc<=correct_pc; state<=S_LOOK; start_decode=0 next cycle.
  - buf_valid kept.
  - if in S_WAIT_LO/S_WAIT_HI, set drop=1.
  - while drop=1, the next resp is discarded (buffer untouched) and drop clears.
  - simultaneous issue_signal is ignored.
- At most one outstanding request ever.
- PC increments on the 32-bit wrap from 0xFFFF_FFFE to 0x0000_0000 are natural modulo 2^32. The word after 0xFFFF_FFFC is 0.
- Reset mid-wait: a later stray response is not guarded by drop (drop=0 after reset). The icache is reset by the same rst_in, so no stray response arrives.

Decomposition:
- Shared include (with existing Const.v):
  - state encodings S_LOOK/S_WAIT_LO/S_WAIT_HI/S_VALID.
  - RVC length test as a macro.
- Sub-module fetch_align: combinational. Inputs are a word, pc[1], and an optional upper word. Outputs are is_compressed, needs_next_word and the assembled inst.

Test Plan:
1. Reset, RESET_PC=0, mem[0]=32'h00A00093 → req addr 0; resp → start_decode=1, inst=00A00093, inst_addr=0; issue with next_pc=4 → req addr 4.
2. mem[0x10]=32'h4505_4585 (two c.li), pc=0x10:
   - inst=0000_4585, addr=0x10.
   - issue next_pc=0x12 → inst=0000_4505, addr=0x12, with no icache request.
3. pc=0x22, mem[0x20]=32'h0093_0001 (c.nop, then low half 0093), mem[0x24]=32'h0000_00A0 (upper half 00A0):
   - after the c.nop at 0x20, inst=00A00093, addr=0x22.
   - exactly two requests (0x20, 0x24).
4. Miss request sent; wrong_predicted with correct_pc=0x100 before resp:
   - old resp is discarded (no start_decode).
   - next request is for 0x100 only after the discarded resp.
   - inst_addr=0x100.
5. S_VALID with issue_signal=0 for 5 cycles → inst/inst_addr/start_decode stable; then issue → new fetch.
6. rst_in low while in S_WAIT_HI → outputs zero immediately; after release, req to RESET_PC; rdy_in=0 for 3 cycles mid-S_LOOK → no request until rdy_in returns.
